// File: rtl/riscv_instr_encoder_if.sv
// Field-bundle handshake and instruction-memory write bus for the RV32I encoder.
// The master drives decoded fields and prog_start; the slave returns in_ready and the memory-side strobes.
interface riscv_instr_encoder_if #(parameter int DEPTH_LOG2 = 6);
  logic                  prog_start;
  logic                  in_valid;
  logic                  in_ready;
  logic [2:0]            in_class;
  logic [2:0]            in_alu_fn;
  logic [4:0]            in_rd;
  logic [4:0]            in_rs1;
  logic [4:0]            in_rs2;
  logic [31:0]           in_imm;
  logic                  mem_we;
  logic [DEPTH_LOG2-1:0] mem_addr;
  logic [31:0]           mem_wdata;
  logic                  err;
  logic                  full;
  logic [DEPTH_LOG2:0]   count;

  modport master (
    output prog_start, in_valid, in_class, in_alu_fn, in_rd, in_rs1, in_rs2, in_imm,
    input  in_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );

  modport slave (
    input  prog_start, in_valid, in_class, in_alu_fn, in_rd, in_rs1, in_rs2, in_imm,
    output in_ready, mem_we, mem_addr, mem_wdata, err, full, count
  );
endinterface

// File: rtl/riscv_instr_encoder.sv
// Streaming RV32I instruction encoder: registers a decoded field bundle, encodes it next cycle
// and writes the word to instruction memory at an auto-incrementing address.
module riscv_instr_encoder #(
  parameter int DEPTH_LOG2 = 6
) (
  input logic                  clk,
  input logic                  rst_n,
  riscv_instr_encoder_if.slave bus
);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, FULL} state_t;

  state_t                state_q;
  logic [2:0]            class_q;
  logic [2:0]            aluFn_q;
  logic [4:0]            rd_q;
  logic [4:0]            rs1_q;
  logic [4:0]            rs2_q;
  logic [31:0]           imm_q;
  logic [DEPTH_LOG2-1:0] ptr_q;
  logic [DEPTH_LOG2:0]   count_q;
  logic                  memWe_q;
  logic                  err_q;
  logic                  full_q;
  logic [DEPTH_LOG2-1:0] addr_q;
  logic [31:0]           wdata_q;

  logic        aluOk;
  logic        isSub;
  logic [2:0]  aluF3;
  logic        legal;
  logic [31:0] encWord;
  logic        fitsI;
  logic        fitsB;
  logic        fitsJ;

  assign bus.in_ready  = (state_q == LOAD) && !bus.prog_start;
  assign bus.mem_we    = memWe_q;
  assign bus.mem_addr  = addr_q;
  assign bus.mem_wdata = wdata_q;
  assign bus.err       = err_q;
  assign bus.full      = full_q;
  assign bus.count     = count_q;

  // A value fits a signed N-bit field when every bit above the field's sign bit matches it.
  assign fitsI = (imm_q[31:11] == '0) || (imm_q[31:11] == '1);
  assign fitsB = ((imm_q[31:12] == '0) || (imm_q[31:12] == '1)) && !imm_q[0];
  assign fitsJ = ((imm_q[31:20] == '0) || (imm_q[31:20] == '1)) && !imm_q[0];

  always_comb begin
    aluOk = 1'b1;
    isSub = 1'b0;
    aluF3 = 3'b000;
    case (aluFn_q)
      3'b000:  aluF3 = 3'b000;
      3'b001:  isSub = 1'b1;
      3'b010:  aluF3 = 3'b111;
      3'b011:  aluF3 = 3'b110;
      3'b101:  aluF3 = 3'b010;
      default: aluOk = 1'b0;
    endcase
  end

  always_comb begin
    legal   = 1'b0;
    encWord = '0;
    case (class_q)
      3'd0: begin
        legal   = aluOk;
        encWord = {1'b0, isSub, 5'b0, rs2_q, rs1_q, aluF3, rd_q, 7'b0110011};
      end
      3'd1: begin
        legal   = aluOk && !isSub && fitsI;
        encWord = {imm_q[11:0], rs1_q, aluF3, rd_q, 7'b0010011};
      end
      3'd2: begin
        legal   = fitsI;
        encWord = {imm_q[11:0], rs1_q, 3'b010, rd_q, 7'b0000011};
      end
      3'd3: begin
        legal   = fitsI;
        encWord = {imm_q[11:5], rs2_q, rs1_q, 3'b010, imm_q[4:0], 7'b0100011};
      end
      3'd4: begin
        legal   = fitsB;
        encWord = {imm_q[12], imm_q[10:5], rs2_q, rs1_q, 3'b000, imm_q[4:1], imm_q[11], 7'b1100011};
      end
      3'd5: begin
        legal   = fitsJ;
        encWord = {imm_q[20], imm_q[10:1], imm_q[11], imm_q[19:12], rd_q, 7'b1101111};
      end
      default: legal = 1'b0;
    endcase
  end

  // prog_start is applied last so a write already in flight still lands before the pointer clears.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
      class_q <= '0;
      aluFn_q <= '0;
      rd_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      imm_q   <= '0;
      ptr_q   <= '0;
      count_q <= '0;
      memWe_q <= 1'b0;
      err_q   <= 1'b0;
      full_q  <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      memWe_q <= 1'b0;
      err_q   <= 1'b0;
      case (state_q)
        IDLE: state_q <= IDLE;
        LOAD: begin
          if (bus.in_valid && bus.in_ready) begin
            class_q <= bus.in_class;
            aluFn_q <= bus.in_alu_fn;
            rd_q    <= bus.in_rd;
            rs1_q   <= bus.in_rs1;
            rs2_q   <= bus.in_rs2;
            imm_q   <= bus.in_imm;
            state_q <= WRITE;
          end
        end
        WRITE: begin
          if (legal) begin
            memWe_q <= 1'b1;
            addr_q  <= ptr_q;
            wdata_q <= encWord;
            ptr_q   <= ptr_q + 1'b1;
            count_q <= count_q + 1'b1;
            if (ptr_q == '1) begin
              full_q  <= 1'b1;
              state_q <= FULL;
            end else begin
              state_q <= LOAD;
            end
          end else begin
            err_q   <= 1'b1;
            state_q <= LOAD;
          end
        end
        FULL:    state_q <= FULL;
        default: state_q <= IDLE;
      endcase
      if (bus.prog_start) begin
        ptr_q   <= '0;
        count_q <= '0;
        full_q  <= 1'b0;
        state_q <= LOAD;
      end
    end
  end

endmodule

// File: tb/tb_riscv_instr_encoder.sv
// Bench for riscv_instr_encoder: a 64-word and a 4-word instance share stimulus and are each
// checked every cycle against a transaction-level model built from the RV32I encoding rules.
module tb_riscv_instr_encoder;

  typedef struct packed {
    logic [2:0]  cls;
    logic [2:0]  fn;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
  } bundle_t;

  logic    clk;
  logic    rstN;
  logic    progStart;
  logic    inValid;
  bundle_t cur;

  int testCount = 0;
  int failCount = 0;

  riscv_instr_encoder_if #(.DEPTH_LOG2(6)) busA ();
  riscv_instr_encoder_if #(.DEPTH_LOG2(2)) busB ();

  riscv_instr_encoder #(.DEPTH_LOG2(6)) dutA (.clk(clk), .rst_n(rstN), .bus(busA));
  riscv_instr_encoder #(.DEPTH_LOG2(2)) dutB (.clk(clk), .rst_n(rstN), .bus(busB));

  assign busA.prog_start = progStart;
  assign busA.in_valid   = inValid;
  assign busA.in_class   = cur.cls;
  assign busA.in_alu_fn  = cur.fn;
  assign busA.in_rd      = cur.rd;
  assign busA.in_rs1     = cur.rs1;
  assign busA.in_rs2     = cur.rs2;
  assign busA.in_imm     = cur.imm;
  assign busB.prog_start = progStart;
  assign busB.in_valid   = inValid;
  assign busB.in_class   = cur.cls;
  assign busB.in_alu_fn  = cur.fn;
  assign busB.in_rd      = cur.rd;
  assign busB.in_rs1     = cur.rs1;
  assign busB.in_rs2     = cur.rs2;
  assign busB.in_imm     = cur.imm;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Model state per instance: index 0 is the 64-word memory, index 1 the 4-word memory.
  int          depth [2] = '{64, 4};
  bit          mStarted [2];
  bit          mPending [2];
  bit          mFull [2];
  int          mPtr [2];
  int          mCount [2];
  bit          mWe [2];
  bit          mErr [2];
  int          mAddr [2];
  logic [31:0] mWdata [2];
  bundle_t     mBundle [2];

  function automatic longint pw(int n);
    return longint'(1) << n;
  endfunction

  function automatic longint umod(longint v, longint m);
    return ((v % m) + m) % m;
  endfunction

  function automatic longint fnF3(logic [2:0] fn);
    case (fn)
      3'd2:    return 7;
      3'd3:    return 6;
      3'd5:    return 2;
      default: return 0;
    endcase
  endfunction

  function automatic bit tbLegal(bundle_t b);
    longint imm  = longint'($signed(b.imm));
    bit     fnOk = (b.fn == 3'd0) || (b.fn == 3'd1) || (b.fn == 3'd2) || (b.fn == 3'd3) || (b.fn == 3'd5);
    case (b.cls)
      3'd0:       return fnOk;
      3'd1:       return fnOk && (b.fn != 3'd1) && imm >= -2048 && imm <= 2047;
      3'd2, 3'd3: return imm >= -2048 && imm <= 2047;
      3'd4:       return imm >= -4096 && imm <= 4094 && (imm % 2) == 0;
      3'd5:       return imm >= -1048576 && imm <= 1048574 && (imm % 2) == 0;
      default:    return 1'b0;
    endcase
  endfunction

  function automatic logic [31:0] tbEncode(bundle_t b);
    longint imm = longint'($signed(b.imm));
    longint rd  = longint'(b.rd);
    longint rs1 = longint'(b.rs1);
    longint rs2 = longint'(b.rs2);
    longint u12 = umod(imm, 4096);
    longint u13 = umod(imm, 8192);
    longint u21 = umod(imm, pw(21));
    longint w   = 0;
    case (b.cls)
      3'd0: w = ((b.fn == 3'd1) ? 32 : 0) * pw(25) + rs2 * pw(20) + rs1 * pw(15)
                + fnF3(b.fn) * pw(12) + rd * pw(7) + 51;
      3'd1: w = u12 * pw(20) + rs1 * pw(15) + fnF3(b.fn) * pw(12) + rd * pw(7) + 19;
      3'd2: w = u12 * pw(20) + rs1 * pw(15) + 2 * pw(12) + rd * pw(7) + 3;
      3'd3: w = (u12 / 32) * pw(25) + rs2 * pw(20) + rs1 * pw(15) + 2 * pw(12)
                + (u12 % 32) * pw(7) + 35;
      3'd4: w = (u13 / 4096) * pw(31) + ((u13 / 32) % 64) * pw(25) + rs2 * pw(20)
                + rs1 * pw(15) + ((u13 / 2) % 16) * pw(8) + ((u13 / 2048) % 2) * pw(7) + 99;
      3'd5: w = (u21 / pw(20)) * pw(31) + ((u21 / 2) % 1024) * pw(21) + ((u21 / 2048) % 2) * pw(20)
                + ((u21 / 4096) % 256) * pw(12) + rd * pw(7) + 111;
      default: w = 0;
    endcase
    return w[31:0];
  endfunction

  function automatic bit expReady(int i);
    return mStarted[i] && !mPending[i] && !mFull[i] && !progStart;
  endfunction

  task automatic modelReset(int i);
    mStarted[i] = 0; mPending[i] = 0; mFull[i] = 0; mPtr[i] = 0; mCount[i] = 0;
    mWe[i] = 0; mErr[i] = 0; mAddr[i] = 0; mWdata[i] = '0; mBundle[i] = '0;
  endtask

  task automatic modelStep(int i);
    if (!rstN) begin
      modelReset(i);
    end else begin
      bit wasPending = mPending[i];
      mWe[i]  = 0;
      mErr[i] = 0;
      if (wasPending) begin
        mPending[i] = 0;
        if (tbLegal(mBundle[i])) begin
          mWe[i]    = 1;
          mAddr[i]  = mPtr[i];
          mWdata[i] = tbEncode(mBundle[i]);
          mCount[i] = mCount[i] + 1;
          if (mPtr[i] == depth[i] - 1) mFull[i] = 1;
          mPtr[i] = (mPtr[i] + 1) % depth[i];
        end else begin
          mErr[i] = 1;
        end
      end else if (mStarted[i] && !mFull[i] && !progStart && inValid) begin
        mPending[i] = 1;
        mBundle[i]  = cur;
      end
      if (progStart) begin
        mStarted[i] = 1; mPending[i] = 0; mFull[i] = 0; mPtr[i] = 0; mCount[i] = 0;
      end
    end
  endtask

  task automatic checkOutput(string tag, logic [31:0] got, logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic checkInst(string pfx, int i, logic we, logic er, logic [31:0] addr,
                           logic [31:0] wdata, logic fl, logic [31:0] cnt);
    checkOutput({pfx, ".mem_we"}, 32'(we), 32'(mWe[i]));
    checkOutput({pfx, ".err"}, 32'(er), 32'(mErr[i]));
    checkOutput({pfx, ".mem_addr"}, addr, 32'(mAddr[i]));
    checkOutput({pfx, ".mem_wdata"}, wdata, mWdata[i]);
    checkOutput({pfx, ".full"}, 32'(fl), 32'(mFull[i]));
    checkOutput({pfx, ".count"}, cnt, 32'(mCount[i]));
  endtask

  // One clock: drive after the falling edge, check in_ready before the rising edge,
  // advance the model on the rising edge and check registered outputs at the next falling edge.
  task automatic applyStimulus(bit r, bit ps, bit v, bundle_t b);
    rstN = r; progStart = ps; inValid = v; cur = b;
    #1;
    checkOutput("A.in_ready", 32'(busA.in_ready), 32'(expReady(0)));
    checkOutput("B.in_ready", 32'(busB.in_ready), 32'(expReady(1)));
    @(posedge clk);
    modelStep(0);
    modelStep(1);
    @(negedge clk);
    checkInst("A", 0, busA.mem_we, busA.err, 32'(busA.mem_addr), busA.mem_wdata, busA.full, 32'(busA.count));
    checkInst("B", 1, busB.mem_we, busB.err, 32'(busB.mem_addr), busB.mem_wdata, busB.full, 32'(busB.count));
  endtask

  task automatic sendBundle(bundle_t b);
    applyStimulus(1'b1, 1'b0, 1'b1, b);
    applyStimulus(1'b1, 1'b0, 1'b0, b);
  endtask

  function automatic bundle_t mk(int cls, int fn, int rd, int rs1, int rs2, int imm);
    bundle_t b;
    b.cls = 3'(cls); b.fn = 3'(fn); b.rd = 5'(rd); b.rs1 = 5'(rs1); b.rs2 = 5'(rs2); b.imm = 32'(imm);
    return b;
  endfunction

  int edgeImm [15] = '{-2048, 2047, 2048, -2049, -4096, 4094, 4095, 4096, -4098,
                       1048574, 1048576, -1048576, -1048578, -1048577, 0};

  function automatic bundle_t randBundle();
    bundle_t b;
    int k = int'($urandom_range(0, 15));
    int t;
    b.cls = (k < 14) ? 3'(k % 6) : 3'(k - 8);
    b.fn  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'(($urandom_range(0, 1) == 0) ? 0 : 2 + $urandom_range(0, 1));
    b.rd  = 5'($urandom);
    b.rs1 = 5'($urandom);
    b.rs2 = 5'($urandom);
    case ($urandom_range(0, 3))
      0:       t = int'($urandom_range(0, 64)) - 32;
      1:       t = edgeImm[$urandom_range(0, 14)];
      2:       t = int'($urandom);
      default: t = int'($urandom_range(0, 4000)) - 2000;
    endcase
    b.imm = 32'(t);
    return b;
  endfunction

  bundle_t idleB;

  initial begin
    idleB = '0;
    rstN = 1'b0; progStart = 1'b0; inValid = 1'b0; cur = '0;
    repeat (2) @(negedge clk);
    modelReset(0);
    modelReset(1);

    repeat (2) applyStimulus(1'b0, 1'b0, 1'b0, idleB);
    applyStimulus(1'b1, 1'b0, 1'b1, idleB);
    applyStimulus(1'b1, 1'b1, 1'b0, idleB);

    sendBundle(mk(0, 0, 3, 1, 2, 0));
    checkOutput("tpAddWord", busA.mem_wdata, 32'h002081B3);
    checkOutput("tpAddAddr", 32'(busA.mem_addr), 32'd0);
    sendBundle(mk(0, 1, 5, 6, 7, 0));
    checkOutput("tpSubWord", busA.mem_wdata, 32'h407302B3);
    checkOutput("tpSubCount", 32'(busA.count), 32'd2);
    sendBundle(mk(2, 0, 6, 9, 0, -4));
    checkOutput("tpLwWord", busA.mem_wdata, 32'hFFC4A303);
    sendBundle(mk(3, 0, 0, 9, 6, 8));
    checkOutput("tpSwWord", busA.mem_wdata, 32'h0064A423);
    checkOutput("tpFullB", 32'(busB.full), 32'd1);
    sendBundle(mk(4, 0, 0, 4, 4, -8));
    checkOutput("tpBeqWord", busA.mem_wdata, 32'hFE420CE3);
    checkOutput("tpFifthHeldB", 32'(busB.count), 32'd4);
    sendBundle(mk(4, 0, 0, 4, 4, 3));
    checkOutput("tpBeqOddErr", 32'(busA.err), 32'd1);
    checkOutput("tpBeqOddCount", 32'(busA.count), 32'd5);
    sendBundle(mk(1, 1, 1, 2, 0, 5));
    checkOutput("tpIaluSubErr", 32'(busA.err), 32'd1);
    sendBundle(mk(2, 0, 1, 2, 0, 2048));
    checkOutput("tpLwRangeErr", 32'(busA.err), 32'd1);
    sendBundle(mk(7, 0, 1, 2, 3, 0));
    checkOutput("tpClass7Err", 32'(busA.err), 32'd1);

    applyStimulus(1'b1, 1'b1, 1'b0, idleB);
    checkOutput("tpRestartFullB", 32'(busB.full), 32'd0);
    sendBundle(mk(5, 0, 1, 0, 0, -2));
    checkOutput("tpRestartAddrB", 32'(busB.mem_addr), 32'd0);
    applyStimulus(1'b1, 1'b1, 1'b1, mk(0, 0, 1, 1, 1, 0));
    applyStimulus(1'b1, 1'b0, 1'b0, idleB);
    applyStimulus(1'b1, 1'b0, 1'b1, mk(0, 0, 2, 2, 2, 0));
    applyStimulus(1'b0, 1'b0, 1'b0, idleB);
    checkOutput("tpResetWriteWe", 32'(busA.mem_we), 32'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, idleB);
    applyStimulus(1'b1, 1'b1, 1'b0, idleB);

    for (int n = 0; n < 2500; n++) begin
      bit r  = ($urandom_range(0, 299) != 0);
      bit ps = ($urandom_range(0, 39) == 0) || (mFull[0] && $urandom_range(0, 3) == 0)
               || (!mStarted[0] && $urandom_range(0, 2) == 0);
      bit v  = ($urandom_range(0, 9) < 7);
      applyStimulus(r, ps, v, randBundle());
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

endmodule
